// File: rtl/pe_operand_sequencer.sv
// Feeds the fp16 PE: buffers window pixels, pairs them with a stored kernel, and emits K-cycle bursts.
// Outputs are registered (burst starts one edge after a full window is available); pix_ready tracks FIFO fullness only.
module pe_operand_sequencer #(
   parameter int DATA_WIDTH    = 16,
   parameter int WEIGHT_LENGTH = 3,
   parameter int WEIGHT_WIDTH  = 3,
   parameter int FIFO_DEPTH    = 16,
   parameter int GAP           = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  w_valid,
   input  logic [DATA_WIDTH-1:0] w_data,
   output logic                  w_ready,
   input  logic                  w_reload,
   input  logic                  pix_valid,
   input  logic [DATA_WIDTH-1:0] pix_data,
   output logic                  pix_ready,
   output logic [DATA_WIDTH-1:0] floatA,
   output logic [DATA_WIDTH-1:0] floatB,
   output logic                  conv_en,
   output logic                  weights_loaded,
   output logic                  busy
);
   localparam int K  = WEIGHT_LENGTH * WEIGHT_WIDTH;
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [KW-1:0] K_LAST    = KW'(K - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
   localparam logic [CW-1:0] K_CNT     = CW'(K);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);

   generate
      if (FIFO_DEPTH < K) begin : g_bad_depth
         $error("pe_operand_sequencer: FIFO_DEPTH must be >= WEIGHT_LENGTH*WEIGHT_WIDTH");
      end
      if (GAP < 1) begin : g_bad_gap
         $error("pe_operand_sequencer: GAP must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {S_LOAD_W, S_IDLE, S_BURST, S_GAP} state_t;

   state_t                state_q, state_d;
   logic [KW-1:0]         w_idx_q, w_idx_d;
   logic [KW-1:0]         cnt_q, cnt_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic                  reload_q, reload_d;
   logic                  loaded_q, loaded_d;
   logic                  conv_en_q, conv_en_d;
   logic [DATA_WIDTH-1:0] float_a_q, float_a_d;
   logic [DATA_WIDTH-1:0] float_b_q, float_b_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;

   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] weight_mem [K];

   logic          push;
   logic          pop;
   logic          w_take;
   logic          decide;
   logic [KW-1:0] cnt_nxt;

   assign pix_ready      = (count_q < DEPTH_CNT);
   assign push           = pix_valid & pix_ready;
   assign w_ready        = (state_q == S_LOAD_W);
   assign w_take         = w_valid & w_ready & ~w_reload;
   assign cnt_nxt        = cnt_q + KW'(1);
   assign floatA         = float_a_q;
   assign floatB         = float_b_q;
   assign conv_en        = conv_en_q;
   assign weights_loaded = loaded_q;
   assign busy           = (state_q == S_BURST) | (state_q == S_GAP);

   always_comb begin
      state_d   = state_q;
      w_idx_d   = w_idx_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      reload_d  = reload_q;
      loaded_d  = loaded_q;
      conv_en_d = 1'b0;
      float_a_d = '0;
      float_b_d = '0;
      pop       = 1'b0;
      decide    = 1'b0;

      case (state_q)
         S_LOAD_W: begin
            if (w_reload) begin
               w_idx_d = '0;
            end else if (w_valid) begin
               if (w_idx_q == K_LAST) begin
                  w_idx_d  = '0;
                  loaded_d = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  w_idx_d = w_idx_q + KW'(1);
               end
            end
         end
         S_IDLE: decide = 1'b1;
         S_BURST: begin
            if (w_reload) reload_d = 1'b1;
            if (cnt_q == K_LAST) begin
               state_d = S_GAP;
               gap_d   = '0;
            end else begin
               cnt_d     = cnt_nxt;
               pop       = 1'b1;
               conv_en_d = 1'b1;
               float_a_d = fifo_mem[rd_ptr_q];
               float_b_d = weight_mem[cnt_nxt];
            end
         end
         S_GAP: begin
            if (w_reload) reload_d = 1'b1;
            if (gap_q == GAP_LAST) decide = 1'b1;
            else gap_d = gap_q + GW'(1);
         end
         default: state_d = S_LOAD_W;
      endcase

      // The last GAP cycle decides like IDLE so back-to-back windows lose only GAP cycles.
      if (decide) begin
         if (reload_q | w_reload) begin
            state_d  = S_LOAD_W;
            loaded_d = 1'b0;
            reload_d = 1'b0;
            w_idx_d  = '0;
         end else if (loaded_q && (count_q >= K_CNT)) begin
            state_d   = S_BURST;
            cnt_d     = '0;
            pop       = 1'b1;
            conv_en_d = 1'b1;
            float_a_d = fifo_mem[rd_ptr_q];
            float_b_d = weight_mem[0];
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_LOAD_W;
         w_idx_q   <= '0;
         cnt_q     <= '0;
         gap_q     <= '0;
         reload_q  <= 1'b0;
         loaded_q  <= 1'b0;
         conv_en_q <= 1'b0;
         float_a_q <= '0;
         float_b_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         w_idx_q   <= w_idx_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         reload_q  <= reload_d;
         loaded_q  <= loaded_d;
         conv_en_q <= conv_en_d;
         float_a_q <= float_a_d;
         float_b_q <= float_b_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // Storage arrays need no reset: pointers and the loaded flag define what is valid.
   always_ff @(posedge clk) begin
      if (push)   fifo_mem[wr_ptr_q]  <= pix_data;
      if (w_take) weight_mem[w_idx_q] <= w_data;
   end
endmodule

// File: tb/tb_pe_operand_sequencer.sv
// Self-checking bench for pe_operand_sequencer: pixel scoreboard checked every cycle plus per-scenario tasks.
module tb_pe_operand_sequencer;
   localparam int K = 9;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        w_valid = 1'b0;
   logic [15:0] w_data = '0;
   logic        w_ready;
   logic        w_reload = 1'b0;
   logic        pix_valid = 1'b0;
   logic [15:0] pix_data = '0;
   logic        pix_ready;
   logic [15:0] floatA, floatB;
   logic        conv_en, weights_loaded, busy;

   typedef struct {
      logic [15:0] pix;
      int          pos;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] tb_wts [K];
   int          win_pos = 0;
   int          total = 0;
   int          bad = 0;
   int          run = 0;
   int          low = 0;
   int          last_gap = 0;
   int          bursts_done = 0;

   pe_operand_sequencer dut (
      .clk(clk), .reset(reset),
      .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready), .w_reload(w_reload),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .floatA(floatA), .floatB(floatB), .conv_en(conv_en),
      .weights_loaded(weights_loaded), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
      $fatal(1, "timeout");
   end

   // Scoreboard monitor: every conv_en cycle must match the next queued pixel and its kernel weight.
   always @(negedge clk) begin
      if (reset) begin
         run = 0;
         low = 0;
      end else if (conv_en) begin
         if (run == 0) last_gap = low;
         run++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL burst_data: conv_en high with empty scoreboard, floatA=%h floatB=%h", floatA, floatB);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (floatA !== e.pix || floatB !== tb_wts[e.pos]) begin
               bad++;
               $display("FAIL burst_data: got A=%h B=%h, required A=%h B=%h", floatA, floatB, e.pix, tb_wts[e.pos]);
            end
         end
      end else begin
         total++;
         if (floatA !== 16'h0 || floatB !== 16'h0) begin
            bad++;
            $display("FAIL idle_zero: got A=%h B=%h with conv_en=0, required 0000/0000", floatA, floatB);
         end
         if (run != 0) begin
            total++;
            if (run != K) begin
               bad++;
               $display("FAIL burst_len: got %0d cycles, required %0d", run, K);
            end
            bursts_done++;
            low = 0;
         end
         run = 0;
         low++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      w_valid = 1'b0; w_reload = 1'b0; pix_valid = 1'b0;
      exp_q.delete();
      win_pos = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic load_weights(input logic [15:0] base, input logic [15:0] step);
      for (int i = 0; i < K; i++) begin
         w_valid = 1'b1;
         w_data  = base + 16'(i) * step;
         tb_wts[i] = w_data;
         tick();
      end
      w_valid = 1'b0;
   endtask

   task automatic push_pixels(input logic [15:0] base, input logic [15:0] step, input int n, output int accepted);
      accepted = 0;
      for (int i = 0; i < n; i++) begin
         pix_valid = 1'b1;
         pix_data  = base + 16'(i) * step;
         if (pix_ready) begin
            exp_q.push_back('{pix: pix_data, pos: win_pos});
            win_pos = (win_pos + 1) % K;
            accepted++;
         end
         tick();
      end
      pix_valid = 1'b0;
   endtask

   task automatic wait_conv(output bit ok);
      for (int i = 0; i < 60 && !conv_en; i++) tick();
      ok = conv_en;
   endtask

   task automatic wait_bursts(input int target, output bit ok);
      for (int i = 0; i < 200 && bursts_done < target; i++) tick();
      ok = (bursts_done >= target);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3;
      total++;
      if ({conv_en, floatA, floatB, weights_loaded, busy, w_ready, pix_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL reset_state: conv_en=%b A=%h B=%h wl=%b busy=%b w_ready=%b pix_ready=%b, required 0 0 0 0 0 1 1",
                  conv_en, floatA, floatB, weights_loaded, busy, w_ready, pix_ready);
      end
      do_reset();
   endtask

   task automatic test_single_window();
      int acc;
      bit ok;
      int target;
      load_weights(16'h4000, 16'h0);
      total++;
      if (weights_loaded !== 1'b1 || w_ready !== 1'b0) begin
         bad++;
         $display("FAIL load_done: weights_loaded=%b w_ready=%b, required 1 0", weights_loaded, w_ready);
      end
      target = bursts_done + 1;
      push_pixels(16'h3C00, 16'h0, K, acc);
      wait_conv(ok);
      total++;
      if (!ok || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_start: conv_en=%b busy=%b, required 1 1", conv_en, busy);
      end
      wait_bursts(target, ok);
      total++;
      if (!ok || exp_q.size() != 0) begin
         bad++;
         $display("FAIL single_done: bursts=%0d left=%0d, required %0d 0", bursts_done, exp_q.size(), target);
      end
   endtask

   task automatic test_back_to_back();
      int acc;
      bit ok;
      int target;
      w_reload = 1'b1;
      tick();
      w_reload = 1'b0;
      total++;
      if (w_ready !== 1'b1 || weights_loaded !== 1'b0) begin
         bad++;
         $display("FAIL reload_idle: w_ready=%b weights_loaded=%b, required 1 0", w_ready, weights_loaded);
      end
      load_weights(16'h3C00, 16'h1);
      target = bursts_done + 2;
      push_pixels(16'h1000, 16'h3, 2 * K, acc);
      wait_bursts(target, ok);
      total++;
      if (!ok || last_gap != 1) begin
         bad++;
         $display("FAIL b2b_gap: bursts=%0d gap=%0d, required %0d 1", bursts_done, last_gap, target);
      end
   endtask

   task automatic test_fifo_full();
      int acc;
      bit ok;
      int target;
      do_reset();
      push_pixels(16'h5000, 16'h1, 20, acc);
      total++;
      if (acc != 16 || pix_ready !== 1'b0) begin
         bad++;
         $display("FAIL fifo_full: accepted=%0d pix_ready=%b, required 16 0", acc, pix_ready);
      end
      load_weights(16'h3800, 16'h2);
      total++;
      if (pix_ready !== 1'b0 || conv_en !== 1'b0) begin
         bad++;
         $display("FAIL full_pre_burst: pix_ready=%b conv_en=%b, required 0 0", pix_ready, conv_en);
      end
      target = bursts_done + 1;
      tick();
      total++;
      if (conv_en !== 1'b1 || pix_ready !== 1'b1) begin
         bad++;
         $display("FAIL full_first_pop: conv_en=%b pix_ready=%b, required 1 1", conv_en, pix_ready);
      end
      wait_bursts(target, ok);
      total++;
      if (!ok || exp_q.size() != 7) begin
         bad++;
         $display("FAIL full_drain: bursts=%0d left=%0d, required %0d 7", bursts_done, exp_q.size(), target);
      end
   endtask

   task automatic test_reload_in_burst();
      int acc;
      bit ok;
      push_pixels(16'h5100, 16'h1, 2, acc);
      wait_conv(ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL reload_start: conv_en=%b, required 1", conv_en);
      end
      repeat (3) tick();
      w_reload = 1'b1;
      tick();
      w_reload = 1'b0;
      repeat (5) tick();
      total++;
      if (conv_en !== 1'b0 || busy !== 1'b1 || w_ready !== 1'b0) begin
         bad++;
         $display("FAIL reload_gap: conv_en=%b busy=%b w_ready=%b, required 0 1 0", conv_en, busy, w_ready);
      end
      tick();
      total++;
      if (w_ready !== 1'b1 || weights_loaded !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reload_load_w: w_ready=%b wl=%b busy=%b, required 1 0 0", w_ready, weights_loaded, busy);
      end
      load_weights(16'h4400, 16'h5);
   endtask

   task automatic test_reset_mid_burst();
      int acc;
      bit ok;
      push_pixels(16'h6000, 16'h1, K, acc);
      wait_conv(ok);
      repeat (4) tick();
      total++;
      if (!ok || conv_en !== 1'b1) begin
         bad++;
         $display("FAIL midrst_setup: conv_en=%b, required 1", conv_en);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if (conv_en !== 1'b0 || floatA !== 16'h0 || floatB !== 16'h0) begin
         bad++;
         $display("FAIL midrst_async: conv_en=%b A=%h B=%h, required 0 0000 0000", conv_en, floatA, floatB);
      end
      do_reset();
      total++;
      if (w_ready !== 1'b1 || weights_loaded !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b1) begin
         bad++;
         $display("FAIL midrst_after: w_ready=%b wl=%b busy=%b pix_ready=%b, required 1 0 0 1",
                  w_ready, weights_loaded, busy, pix_ready);
      end
   endtask

   task automatic test_partial_window();
      int acc;
      bit ok;
      bit seen;
      int target;
      load_weights(16'h3A00, 16'h7);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         seen |= conv_en;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL fifo_empty_after_reset: conv_en seen=%b, required 0", seen);
      end
      push_pixels(16'h7000, 16'h11, K - 1, acc);
      for (int i = 0; i < 6; i++) begin
         tick();
         seen |= conv_en;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL partial_window: conv_en seen=%b with 8 pixels, required 0", seen);
      end
      target = bursts_done + 1;
      push_pixels(16'h7F00, 16'h0, 1, acc);
      total++;
      if (conv_en !== 1'b0) begin
         bad++;
         $display("FAIL ninth_same_edge: conv_en=%b, required 0", conv_en);
      end
      tick();
      total++;
      if (conv_en !== 1'b1 || floatA !== 16'h7000) begin
         bad++;
         $display("FAIL ninth_next_edge: conv_en=%b A=%h, required 1 7000", conv_en, floatA);
      end
      wait_bursts(target, ok);
      total++;
      if (!ok || exp_q.size() != 0) begin
         bad++;
         $display("FAIL partial_done: bursts=%0d left=%0d, required %0d 0", bursts_done, exp_q.size(), target);
      end
   endtask

   initial begin
      test_reset();
      test_single_window();
      test_back_to_back();
      test_fifo_full();
      test_reload_in_burst();
      test_reset_mid_burst();
      test_partial_window();
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
